// File: rtl/seq_pattern_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_gen_pkg
// Brief    : Shared types and constants for the serial pattern generator.
//            ST_GAP exists only when SEQ_PATTERN_GEN_GAP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
package seq_pattern_gen_pkg;

    localparam int   c_DEFAULT_W  = 8;
    localparam logic c_IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
`ifdef SEQ_PATTERN_GEN_GAP_EN
        ST_GAP   = 2'd2,
`endif
        ST_DONE  = 2'd3
    } state_t;

endpackage : seq_pattern_gen_pkg
`default_nettype wire

// File: rtl/seq_pattern_shreg.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_shreg
// Brief    : Loadable W-bit shift register, shifts left so the MSB leaves first.
// Revision : 1.0 - initial release
// ============================================================================
module seq_pattern_shreg
    import seq_pattern_gen_pkg::*;
#(
    parameter int W = c_DEFAULT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic         msb
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= d;
        end else if (shift) begin
            r_q <= {r_q[W-2:0], 1'b0};
        end
    end

    assign msb = r_q[W-1];

endmodule : seq_pattern_shreg
`default_nettype wire

// File: rtl/seq_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_gen
// Brief    : Serial burst generator: sends a left-justified pattern MSB first,
//            repeated rep_m1+1 times. Define SEQ_PATTERN_GEN_GAP_EN to insert
//            one idle GAP cycle between repetitions.
// Revision : 1.0 - initial release
// ============================================================================
module seq_pattern_gen
    import seq_pattern_gen_pkg::*;
#(
    parameter int W = c_DEFAULT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic [W-1:0]         pattern,
    input  logic [$clog2(W)-1:0] len_m1,
    input  logic [3:0]           rep_m1,
    output logic                 x,
    output logic                 valid,
    output logic                 busy,
    output logic                 done
);

    localparam int c_LW = $clog2(W);

    state_t          r_state;
    logic [W-1:0]    r_pat;
    logic [c_LW-1:0] r_len_m1;
    logic [c_LW-1:0] r_bit_cnt;
    logic [3:0]      r_rep_m1;
    logic [3:0]      r_rep_cnt;
    logic            r_x;
    logic            r_valid;
    logic            r_busy;
    logic            r_done;

    logic            w_last_bit;
    logic            w_last_rep;
    logic            w_ld;
    logic            w_sh;
    logic [W-1:0]    w_ld_data;
    logic            w_sh_msb;

    assign w_last_bit = (r_bit_cnt == r_len_m1);
    assign w_last_rep = (r_rep_cnt == r_rep_m1);

    // The register always holds the bits after the one currently on x, so a
    // load pre-shifts the pattern and x takes the MSB directly.
    assign w_ld_data = (r_state == ST_IDLE) ? {pattern[W-2:0], 1'b0}
                                            : {r_pat[W-2:0], 1'b0};
    assign w_ld = ((r_state == ST_IDLE) && start) ||
                  ((r_state == ST_SHIFT) && !stop && w_last_bit && !w_last_rep);
    assign w_sh = (r_state == ST_SHIFT) && !stop && !w_last_bit;

    seq_pattern_shreg #(
        .W (W)
    ) u_shreg (
        .clk   (clk),
        .reset (reset),
        .load  (w_ld),
        .shift (w_sh),
        .d     (w_ld_data),
        .msb   (w_sh_msb)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_pat     <= '0;
            r_len_m1  <= '0;
            r_rep_m1  <= '0;
            r_bit_cnt <= '0;
            r_rep_cnt <= '0;
            r_x       <= c_IDLE_LEVEL;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_pat     <= pattern;
                        r_len_m1  <= len_m1;
                        r_rep_m1  <= rep_m1;
                        r_bit_cnt <= '0;
                        r_rep_cnt <= '0;
                        r_x       <= pattern[W-1];
                        r_valid   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (stop) begin
                        r_x     <= c_IDLE_LEVEL;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (!w_last_bit) begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_x       <= w_sh_msb;
                    end else if (w_last_rep) begin
                        r_x     <= c_IDLE_LEVEL;
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_bit_cnt <= '0;
                        r_rep_cnt <= r_rep_cnt + 1'b1;
`ifdef SEQ_PATTERN_GEN_GAP_EN
                        r_x     <= c_IDLE_LEVEL;
                        r_valid <= 1'b0;
                        r_state <= ST_GAP;
`else
                        r_x     <= r_pat[W-1];
`endif
                    end
                end

`ifdef SEQ_PATTERN_GEN_GAP_EN
                ST_GAP: begin
                    if (stop) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_x     <= r_pat[W-1];
                        r_valid <= 1'b1;
                        r_state <= ST_SHIFT;
                    end
                end
`endif

                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_x     <= c_IDLE_LEVEL;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign x     = r_x;
    assign valid = r_valid;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule : seq_pattern_gen
`default_nettype wire

// File: tb/tb_seq_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_pattern_gen
// Brief    : Directed self-checking bench for seq_pattern_gen; expectations
//            follow SEQ_PATTERN_GEN_GAP_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_gen;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         stop;
    logic [W-1:0] pattern;
    logic [2:0]   len_m1;
    logic [3:0]   rep_m1;
    logic         x;
    logic         valid;
    logic         busy;
    logic         done;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [2:0]   det_hist;
    int           z_count;

    always #5 clk = ~clk;

    seq_pattern_gen #(
        .W (W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .pattern (pattern),
        .len_m1  (len_m1),
        .rep_m1  (rep_m1),
        .x       (x),
        .valid   (valid),
        .busy    (busy),
        .done    (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bit k of each mask (counted from the left over ncyc bits) is the value
    // expected in cycle T+k, where T is the edge that samples start.
    task automatic run_burst(input string tag, input logic [W-1:0] pat,
                             input logic [2:0] len, input logic [3:0] rep,
                             input int ncyc, input logic [63:0] xs,
                             input logic [63:0] vs, input logic [63:0] bs,
                             input logic [63:0] ds, input int stop_at,
                             input int restart_at);
        @(negedge clk);
        pattern = pat;
        len_m1  = len;
        rep_m1  = rep;
        start   = 1'b1;
        stop    = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            check($sformatf("%s x@T+%0d", tag, k),     64'(x),     64'(xs[ncyc-k]));
            check($sformatf("%s valid@T+%0d", tag, k), 64'(valid), 64'(vs[ncyc-k]));
            check($sformatf("%s busy@T+%0d", tag, k),  64'(busy),  64'(bs[ncyc-k]));
            check($sformatf("%s done@T+%0d", tag, k),  64'(done),  64'(ds[ncyc-k]));
            if (valid) begin
                if ({det_hist, x} == 4'b0110) z_count++;
                det_hist = {det_hist[1:0], x};
            end
            start = (k == restart_at);
            stop  = (k == stop_at);
            if (k == restart_at) begin
                pattern = 8'hFF;
                len_m1  = 3'd7;
                rep_m1  = 4'd15;
            end
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        pattern = '0;
        len_m1  = '0;
        rep_m1  = '0;
        #1;
        check("reset x", 64'(x), 64'd1);
        check("reset valid", 64'(valid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        det_hist = 3'b111;
        z_count  = 0;
`ifdef SEQ_PATTERN_GEN_GAP_EN
        run_burst("p0110", 8'h60, 3'd3, 4'd1, 12, 12'b011010110111,
                  12'b111101111000, 12'b111111111100, 12'b000000000100, 0, 0);
`else
        run_burst("p0110", 8'h60, 3'd3, 4'd1, 11, 11'b01100110111,
                  11'b11111111000, 11'b11111111100, 11'b00000000100, 0, 0);
`endif
        check("detector z pulses", 64'(z_count), 64'd2);

        run_burst("stopA5", 8'hA5, 3'd7, 4'd0, 7, 7'b1010111,
                  7'b1111000, 7'b1111000, 7'b0000000, 4, 0);

`ifdef SEQ_PATTERN_GEN_GAP_EN
        run_burst("restart", 8'h60, 3'd3, 4'd1, 14, 14'b01101011011111,
                  14'b11110111100000, 14'b11111111110000, 14'b00000000010000, 0, 3);
        run_burst("single", 8'h80, 3'd0, 4'd15, 33, {33{1'b1}},
                  {{15{2'b10}}, 1'b1, 2'b00}, {{32{1'b1}}, 1'b0},
                  {31'b0, 1'b1, 1'b0}, 0, 0);
        run_burst("fullC3", 8'hC3, 3'd7, 4'd1, 19, 19'b1100001111100001111,
                  {8'hFF, 1'b0, 8'hFF, 2'b00}, {{18{1'b1}}, 1'b0},
                  {17'b0, 1'b1, 1'b0}, 0, 0);
`else
        run_burst("restart", 8'h60, 3'd3, 4'd1, 14, 14'b01100110111111,
                  14'b11111111000000, 14'b11111111100000, 14'b00000000100000, 0, 3);
        run_burst("single", 8'h80, 3'd0, 4'd15, 18, {18{1'b1}},
                  {{16{1'b1}}, 2'b00}, {{17{1'b1}}, 1'b0},
                  {16'b0, 1'b1, 1'b0}, 0, 0);
        run_burst("fullC3", 8'hC3, 3'd7, 4'd1, 18, 18'b110000111100001111,
                  {{16{1'b1}}, 2'b00}, {{17{1'b1}}, 1'b0},
                  {16'b0, 1'b1, 1'b0}, 0, 0);
`endif

        // Asynchronous reset in the middle of a burst.
        @(negedge clk);
        pattern = 8'h60;
        len_m1  = 3'd3;
        rep_m1  = 4'd1;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre-reset valid", 64'(valid), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("async reset x", 64'(x), 64'd1);
        check("async reset valid", 64'(valid), 64'd0);
        check("async reset busy", 64'(busy), 64'd0);
        check("async reset done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("post-reset done c%0d", k), 64'(done), 64'd0);
            check($sformatf("post-reset busy c%0d", k), 64'(busy), 64'd0);
        end

`ifdef SEQ_PATTERN_GEN_GAP_EN
        run_burst("after-reset", 8'h60, 3'd3, 4'd1, 12, 12'b011010110111,
                  12'b111101111000, 12'b111111111100, 12'b000000000100, 0, 0);
`else
        run_burst("after-reset", 8'h60, 3'd3, 4'd1, 11, 11'b01100110111,
                  11'b11111111000, 11'b11111111100, 11'b00000000100, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_seq_pattern_gen
`default_nettype wire
